// File: rtl/entry_arb_pkg.sv
// Shared state encoding and default sizing for the keypad entry arbiter.
package entry_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OWN0    = 3'd1,
    OWN1    = 3'd2,
    GAP     = 3'd3,
    BLOCKED = 3'd4
  } arb_state_t;

  localparam int DEFAULT_DIGITS         = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000000;
  localparam int DEFAULT_GAP_CYCLES     = 2;

endpackage

// File: rtl/inactivity_timer.sv
// Saturating idle-cycle counter; expired flags the last allowed idle cycle of a session.
module inactivity_timer
  import entry_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/entry_arbiter.sv
// Arbitrates two keypads onto the single digit stream of the password FSM,
// one owner per entry session, with round-robin tie-break, timeout and lockout handling.
module entry_arbiter
  import entry_arb_pkg::*;
#(
  parameter int DIGITS         = DEFAULT_DIGITS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [3:0] req0_digit,
  input  logic       req1_valid,
  input  logic [3:0] req1_digit,
  input  logic       unlocked,
  input  logic       permlocked,
  output logic       data_valid,
  output logic [3:0] digit,
  output logic [1:0] grant,
  output logic [1:0] reject,
  output logic       timeout
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [3:0]    LAST_DIGIT = 4'(DIGITS);
  localparam logic [GW-1:0] LAST_GAP   = GW'(GAP_CYCLES - 1);

  arb_state_t    state, state_next;
  logic [3:0]    session_cnt, sess_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic          prefer, prefer_next;
  logic          dv_next, timeout_next;
  logic [3:0]    digit_next;
  logic [1:0]    reject_next;
  logic          forward, expired, in_session;
  logic          pick1, own_is1, own_v, other_v;
  logic [3:0]    own_d;

  assign in_session = (state == OWN0) || (state == OWN1);

  inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (forward || !in_session),
    .enable (in_session),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      session_cnt <= '0;
      gap_cnt     <= '0;
      prefer      <= 1'b0;
      data_valid  <= 1'b0;
      digit       <= '0;
      reject      <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      session_cnt <= sess_next;
      gap_cnt     <= gap_next;
      prefer      <= prefer_next;
      data_valid  <= dv_next;
      digit       <= digit_next;
      reject      <= reject_next;
      timeout     <= timeout_next;
    end
  end

  // Lockout outranks everything; unlocked only suppresses entry while idle or owned.
  always_comb begin
    state_next   = state;
    sess_next    = session_cnt;
    gap_next     = gap_cnt;
    prefer_next  = prefer;
    dv_next      = 1'b0;
    digit_next   = digit;
    reject_next  = 2'b00;
    timeout_next = 1'b0;
    forward      = 1'b0;
    pick1        = 1'b0;
    own_is1      = 1'b0;
    own_v        = 1'b0;
    other_v      = 1'b0;
    own_d        = 4'd0;

    if (permlocked) begin
      state_next  = BLOCKED;
      reject_next = {req1_valid, req0_valid};
    end else begin
      case (state)
        IDLE: begin
          if (unlocked) begin
            reject_next = {req1_valid, req0_valid};
          end else if (req0_valid || req1_valid) begin
            pick1       = req1_valid && (!req0_valid || prefer);
            forward     = 1'b1;
            dv_next     = 1'b1;
            digit_next  = pick1 ? req1_digit : req0_digit;
            reject_next = (req0_valid && req1_valid) ? (pick1 ? 2'b01 : 2'b10) : 2'b00;
            prefer_next = !pick1;
            sess_next   = 4'd1;
            gap_next    = '0;
            if (sess_next == LAST_DIGIT) state_next = GAP;
            else                         state_next = pick1 ? OWN1 : OWN0;
          end
        end

        OWN0, OWN1: begin
          own_is1 = (state == OWN1);
          own_v   = own_is1 ? req1_valid : req0_valid;
          own_d   = own_is1 ? req1_digit : req0_digit;
          other_v = own_is1 ? req0_valid : req1_valid;
          if (unlocked) begin
            state_next  = IDLE;
            reject_next = {req1_valid, req0_valid};
          end else begin
            // A strobe right behind a forwarded digit is dropped to keep data_valid single-cycle.
            if (own_v && !data_valid) begin
              forward    = 1'b1;
              dv_next    = 1'b1;
              digit_next = own_d;
              sess_next  = session_cnt + 4'd1;
              if (sess_next == LAST_DIGIT) begin
                state_next = GAP;
                gap_next   = '0;
              end
            end else if (expired) begin
              timeout_next = 1'b1;
              state_next   = IDLE;
            end
            reject_next = own_is1 ? {own_v && !forward, other_v}
                                  : {other_v, own_v && !forward};
          end
        end

        GAP: begin
          reject_next = {req1_valid, req0_valid};
          if (gap_cnt == LAST_GAP) state_next = IDLE;
          else                     gap_next   = gap_cnt + GW'(1);
        end

        BLOCKED: begin
          reject_next = {req1_valid, req0_valid};
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    case (state)
      OWN0:    grant = 2'b01;
      OWN1:    grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_entry_arbiter.sv
// Directed bench for entry_arbiter: sessions, arbitration, timeout, lockout and unlock.
module tb_entry_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_digit, req1_digit;
  logic       unlocked, permlocked;
  logic       data_valid;
  logic [3:0] digit;
  logic [1:0] grant;
  logic [1:0] reject;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  entry_arbiter #(
    .DIGITS(8),
    .TIMEOUT_CYCLES(20),
    .GAP_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_digit(req0_digit),
    .req1_valid(req1_valid),
    .req1_digit(req1_digit),
    .unlocked  (unlocked),
    .permlocked(permlocked),
    .data_valid(data_valid),
    .digit     (digit),
    .grant     (grant),
    .reject    (reject),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Present strobes for exactly one cycle; returns just after the capturing edge.
  task automatic applyStimulus(input logic v0, input logic [3:0] d0,
                               input logic v1, input logic [3:0] d1);
    req0_valid = v0;
    req0_digit = d0;
    req1_valid = v1;
    req1_digit = d1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_digit = 4'd0;
    req1_valid = 1'b0; req1_digit = 4'd0;
    unlocked = 1'b0;   permlocked = 1'b0;
    doReset();

    checkOutput("rst_grant", grant, 8'd0);
    checkOutput("rst_dv", data_valid, 8'd0);
    checkOutput("rst_digit", digit, 8'd0);
    checkOutput("rst_reject", reject, 8'd0);
    checkOutput("rst_timeout", timeout, 8'd0);

    // Full eight-digit session from source 0.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 4'd0);
      checkOutput("s0_dv", data_valid, 8'd1);
      checkOutput("s0_digit", digit, 8'(i));
      checkOutput("s0_grant", grant, (i < 8) ? 8'd1 : 8'd0);
      if (i < 8) begin
        idle(1);
        checkOutput("s0_dv_low", data_valid, 8'd0);
      end
    end
    applyStimulus(1'b1, 4'd3, 1'b0, 4'd0);
    checkOutput("gap_reject", reject, 8'h1);
    checkOutput("gap_dv", data_valid, 8'd0);
    checkOutput("gap_grant", grant, 8'd0);
    idle(1);

    // Source 1 sends two digits then goes quiet until timeout.
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd4);
    checkOutput("to_grant", grant, 8'h2);
    checkOutput("to_digit", digit, 8'd4);
    idle(1);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd7);
    checkOutput("to_digit2", digit, 8'd7);
    idle(19);
    checkOutput("to_early", timeout, 8'd0);
    checkOutput("to_early_grant", grant, 8'h2);
    idle(1);
    checkOutput("to_pulse", timeout, 8'd1);
    checkOutput("to_grant_clr", grant, 8'd0);
    idle(1);
    checkOutput("to_once", timeout, 8'd0);

    // Owner strobe on the threshold cycle beats the timeout.
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd2);
    checkOutput("thr_grant", grant, 8'h2);
    idle(19);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd6);
    checkOutput("thr_dv", data_valid, 8'd1);
    checkOutput("thr_digit", digit, 8'd6);
    checkOutput("thr_no_to", timeout, 8'd0);
    checkOutput("thr_grant2", grant, 8'h2);
    idle(19);
    checkOutput("thr_to_early", timeout, 8'd0);
    idle(1);
    checkOutput("thr_to_pulse", timeout, 8'd1);
    idle(1);

    // Simultaneous strobes: source 0 favoured; intruder rejected mid-session.
    applyStimulus(1'b1, 4'd1, 1'b1, 4'd2);
    checkOutput("rr1_grant", grant, 8'h1);
    checkOutput("rr1_reject", reject, 8'h2);
    checkOutput("rr1_digit", digit, 8'd1);
    idle(1);
    for (int i = 2; i <= 3; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 4'd0);
      idle(1);
    end
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd9);
    checkOutput("intr_reject", reject, 8'h2);
    checkOutput("intr_dv", data_valid, 8'd0);
    checkOutput("intr_grant", grant, 8'h1);
    idle(1);
    checkOutput("intr_reject_end", reject, 8'd0);
    for (int i = 4; i <= 8; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 4'd0);
      checkOutput("rr1_fwd", digit, 8'(i));
      idle(1);
    end
    checkOutput("rr1_gap_grant", grant, 8'd0);
    idle(1);

    // Second tie goes to source 1, then permanent lock mid-session.
    applyStimulus(1'b1, 4'd3, 1'b1, 4'd4);
    checkOutput("rr2_grant", grant, 8'h2);
    checkOutput("rr2_reject", reject, 8'h1);
    checkOutput("rr2_digit", digit, 8'd4);
    idle(1);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd5);
    checkOutput("rr2_digit2", digit, 8'd5);
    permlocked = 1'b1;
    tick();
    checkOutput("pl_grant", grant, 8'd0);
    applyStimulus(1'b1, 4'd1, 1'b1, 4'd1);
    checkOutput("pl_reject", reject, 8'h3);
    checkOutput("pl_dv", data_valid, 8'd0);
    permlocked = 1'b0;
    idle(1);
    applyStimulus(1'b1, 4'd2, 1'b0, 4'd0);
    checkOutput("pl_stay_reject", reject, 8'h1);
    checkOutput("pl_stay_dv", data_valid, 8'd0);
    checkOutput("pl_stay_grant", grant, 8'd0);

    // Unlocked suppresses entry; normal after it falls.
    doReset();
    unlocked = 1'b1;
    applyStimulus(1'b1, 4'd5, 1'b0, 4'd0);
    checkOutput("ul_dv", data_valid, 8'd0);
    checkOutput("ul_reject", reject, 8'h1);
    checkOutput("ul_grant", grant, 8'd0);
    unlocked = 1'b0;
    idle(1);
    applyStimulus(1'b1, 4'd5, 1'b0, 4'd0);
    checkOutput("ul_after_dv", data_valid, 8'd1);
    checkOutput("ul_after_digit", digit, 8'd5);
    checkOutput("ul_after_grant", grant, 8'h1);
    idle(1);

    // Reset mid-session with a strobe in the reset cycle.
    reset = 1'b1;
    applyStimulus(1'b1, 4'd6, 1'b0, 4'd0);
    reset = 1'b0;
    checkOutput("mid_rst_grant", grant, 8'd0);
    checkOutput("mid_rst_dv", data_valid, 8'd0);
    checkOutput("mid_rst_digit", digit, 8'd0);
    checkOutput("mid_rst_timeout", timeout, 8'd0);
    idle(1);
    checkOutput("mid_rst_dv2", data_valid, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/entry_arbiter.md
ENTRY_ARBITER -- requirements
Module: entry_arbiter

Interface
REQ-001 Parameter DIGITS, default 8: digits forwarded per entry session.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000000: inactivity limit per session, in clk cycles.
REQ-003 Parameter GAP_CYCLES, default 2: quiet cycles after a complete session, so the password FSM can compare.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0_valid  input  1  one-cycle key strobe from source 0 (front keypad).
REQ-007 req0_digit  input  4  digit from source 0, qualified by req0_valid.
REQ-008 req1_valid  input  1  one-cycle key strobe from source 1 (remote keypad).
REQ-009 req1_digit  input  4  digit from source 1, qualified by req1_valid.
REQ-010 unlocked  input  1  password FSM unlocked status.
REQ-011 permlocked  input  1  password FSM permanent-lock status.
REQ-012 data_valid  output  1  registered digit strobe to the password FSM.
REQ-013 digit  output  4  registered digit to the password FSM.
REQ-014 grant  output  2  one-hot current owner; 00 when no owner.
REQ-015 reject  output  2  one-cycle pulse per source whose strobe was dropped.
REQ-016 timeout  output  1  one-cycle pulse when a session is aborted for inactivity.

Function
REQ-017 The block SHALL use five states: IDLE, OWN0, OWN1, GAP, BLOCKED.
REQ-018 In IDLE, a strobe from exactly one source SHALL move to OWNn and forward that digit.
REQ-019 In IDLE, simultaneous strobes SHALL grant the source not granted last (round-robin; source 0 after reset), and the loser SHALL get a reject pulse.
REQ-020 A forwarded digit SHALL appear on digit/data_valid exactly one cycle after the input strobe; data_valid SHALL never be high two cycles in a row.
REQ-021 In OWNn, owner strobes SHALL be forwarded, and non-owner strobes SHALL produce reject[m] one cycle later.
REQ-022 A 4-bit session counter SHALL count forwarded digits and clear when the session is entered.
REQ-023 When the DIGITS-th digit is forwarded, the block SHALL enter GAP, release grant, and remain for GAP_CYCLES cycles, rejecting all strobes, then return to IDLE.
REQ-024 An inactivity counter SHALL clear on every forwarded digit and increment in OWNn.
REQ-025 When the inactivity counter reaches TIMEOUT_CYCLES-1 with no owner strobe that cycle, the block SHALL pulse timeout, clear grant, and return to IDLE.
REQ-026 An owner strobe in the same cycle as the timeout threshold SHALL win: the digit is forwarded and no timeout occurs.
REQ-027 If permlocked is high in any state, the block SHALL enter BLOCKED next cycle, clear grant, and reject every strobe; BLOCKED exits only on reset.
REQ-028 If unlocked is high in IDLE or OWNn, the block SHALL return to IDLE, forward nothing, and reject every strobe while unlocked stays high.
REQ-029 grant SHALL reflect the state (OWN0 -> 01, OWN1 -> 10, otherwise 00) in the same cycle the state register updates.

Reset
REQ-030 On reset the block SHALL set state to IDLE, and grant, data_valid, digit, reject and timeout to 0.
REQ-031 On reset the block SHALL clear both counters and set the round-robin pointer to favour source 0.
REQ-032 Reset mid-session SHALL abort with no timeout pulse, and strobes in the reset cycle SHALL be ignored.

Structure
REQ-033 State encodings and the default DIGITS, TIMEOUT_CYCLES and GAP_CYCLES values SHALL live in a shared package entry_arb_pkg.
REQ-034 The inactivity counter SHALL be a sub-module inactivity_timer, with ports clk, reset, clear, enable and expired, and a width derived from TIMEOUT_CYCLES.

Verification (bench uses TIMEOUT_CYCLES=20)
REQ-035 Reset, then source 0 strobes 1,2,3,4,5,6,7,8 -> data_valid pulses carry 1..8 one cycle after each strobe; grant=01, then 00 for 2 GAP cycles, then IDLE.
REQ-036 Source 0 owns and has sent 3 digits; source 1 strobes 9 -> reject=10 for one cycle, digit 9 never forwarded, grant stays 01.
REQ-037 From IDLE, both sources strobe in the same cycle twice, each after a completed session -> first session grant=01 with reject=10; second session grant=10 with reject=01.
REQ-038 Source 1 sends 2 digits, then idles 20 cycles -> timeout pulses once on the 20th idle cycle and grant=00; an owner strobe on the threshold cycle instead forwards the digit with no timeout.
REQ-039 permlocked rises mid-session -> grant=00 next cycle, all later strobes give reject pulses, data_valid stays 0 until reset.
REQ-040 unlocked held high while source 0 strobes 5 -> no data_valid, reject=01; after unlocked falls, a strobe of 5 is forwarded normally.
